// File: rtl/lane_collector.sv
// ============================================================================
// lane_collector : four per-lane FIFOs merged round-robin into one byte stream
// Optional: COL_OVF_CNT_EN adds a saturating dropped-byte counter (ovf_count)
// Revision: 1.0
// ============================================================================
`default_nettype none

module lane_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk_f,
    input  logic                  default_values,
    input  logic [DATA_WIDTH-1:0] data_out0,
    input  logic [DATA_WIDTH-1:0] data_out1,
    input  logic [DATA_WIDTH-1:0] data_out2,
    input  logic [DATA_WIDTH-1:0] data_out3,
    input  logic                  valid_out0,
    input  logic                  valid_out1,
    input  logic                  valid_out2,
    input  logic                  valid_out3,
    input  logic                  ready_col,
    output logic [DATA_WIDTH-1:0] data_col,
    output logic                  valid_col,
    output logic [1:0]            lane_col,
    output logic [3:0]            fifo_full,
    output logic [3:0]            fifo_empty,
    output logic [3:0]            overflow,
`ifdef COL_OVF_CNT_EN
    output logic [7:0]            ovf_count,
`endif
    output logic                  idle
);

    localparam int                  NUM_LANES = 4;
    localparam logic [ADDR_WIDTH:0] CNT_FULL  = (ADDR_WIDTH+1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } arb_state_t;

    arb_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_col_q, data_col_d;
    logic [1:0]            lane_col_q, lane_col_d;
    logic [1:0]            last_grant_q, last_grant_d;
    logic [3:0]            overflow_q;

    logic [DATA_WIDTH-1:0] lane_data [NUM_LANES];
    logic [DATA_WIDTH-1:0] head      [NUM_LANES];
    logic [NUM_LANES-1:0]  lane_valid, push, pop, drop;
    logic [1:0]            grant, cand;
    logic                  found, load;

    assign lane_data[0] = data_out0;
    assign lane_data[1] = data_out1;
    assign lane_data[2] = data_out2;
    assign lane_data[3] = data_out3;
    assign lane_valid   = {valid_out3, valid_out2, valid_out1, valid_out0};

    // A full lane still accepts a byte when the arbiter pops it on the same edge.
    assign push = lane_valid & (~fifo_full | pop);
    assign drop = lane_valid & fifo_full & ~pop;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
        logic [ADDR_WIDTH:0]   count_q;

        always_ff @(posedge clk_f) begin
            if (!default_values) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push[g]) begin
                    mem_q[wr_ptr_q] <= lane_data[g];
                    wr_ptr_q        <= wr_ptr_q + ADDR_WIDTH'(1);
                end
                if (pop[g]) begin
                    rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
                end
                count_q <= count_q + (ADDR_WIDTH+1)'(push[g]) - (ADDR_WIDTH+1)'(pop[g]);
            end
        end

        assign head[g]       = mem_q[rd_ptr_q];
        assign fifo_empty[g] = (count_q == '0);
        assign fifo_full[g]  = (count_q == CNT_FULL);
    end

    always_comb begin
        grant = last_grant_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            cand = last_grant_q + 2'(k);
            if (!found && !fifo_empty[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    assign load = ((state_q == ST_EMPTY) || ready_col) && (fifo_empty != 4'hF);

    always_comb begin
        state_d      = state_q;
        data_col_d   = data_col_q;
        lane_col_d   = lane_col_q;
        last_grant_d = last_grant_q;
        pop          = '0;
        if (load) begin
            pop[grant]   = 1'b1;
            data_col_d   = head[grant];
            lane_col_d   = grant;
            last_grant_d = grant;
            state_d      = ST_BUSY;
        end else if ((state_q == ST_BUSY) && ready_col) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_f) begin
        if (!default_values) begin
            state_q      <= ST_EMPTY;
            data_col_q   <= '0;
            lane_col_q   <= '0;
            last_grant_q <= 2'd3;
            overflow_q   <= '0;
        end else begin
            state_q      <= state_d;
            data_col_q   <= data_col_d;
            lane_col_q   <= lane_col_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_q | drop;
        end
    end

`ifdef COL_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;
    logic [2:0] ndrop;
    logic [8:0] ovf_sum;

    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            ndrop = ndrop + 3'(drop[i]);
        end
        ovf_sum = {1'b0, ovf_cnt_q} + 9'(ndrop);
    end

    always_ff @(posedge clk_f) begin
        if (!default_values) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
        end
    end

    assign ovf_count = ovf_cnt_q;
`endif

    assign data_col  = data_col_q;
    assign lane_col  = lane_col_q;
    assign valid_col = (state_q == ST_BUSY);
    assign overflow  = overflow_q;
    assign idle      = (fifo_empty == 4'hF) && (state_q == ST_EMPTY);

endmodule

`default_nettype wire

// File: tb/tb_lane_collector.sv
// ============================================================================
// tb_lane_collector : directed self-checking bench for lane_collector
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lane_collector;

    logic       clk_f = 1'b0;
    logic       default_values;
    logic [7:0] din [4];
    logic       vin [4];
    logic       ready_col;
    logic [7:0] data_col;
    logic       valid_col;
    logic [1:0] lane_col;
    logic [3:0] fifo_full, fifo_empty, overflow;
    logic       idle;
`ifdef COL_OVF_CNT_EN
    logic [7:0] ovf_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_f = ~clk_f;

    lane_collector #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .ADDR_WIDTH(2)) u_dut (
        .clk_f          (clk_f),
        .default_values (default_values),
        .data_out0      (din[0]),
        .data_out1      (din[1]),
        .data_out2      (din[2]),
        .data_out3      (din[3]),
        .valid_out0     (vin[0]),
        .valid_out1     (vin[1]),
        .valid_out2     (vin[2]),
        .valid_out3     (vin[3]),
        .ready_col      (ready_col),
        .data_col       (data_col),
        .valid_col      (valid_col),
        .lane_col       (lane_col),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .overflow       (overflow),
`ifdef COL_OVF_CNT_EN
        .ovf_count      (ovf_count),
`endif
        .idle           (idle)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic quiet();
        for (int i = 0; i < 4; i++) vin[i] = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic [1:0] l);
        check_val({tag, "_valid"}, 32'(valid_col), 32'd1);
        check_val({tag, "_data"},  32'(data_col),  32'(d));
        check_val({tag, "_lane"},  32'(lane_col),  32'(l));
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_valid"}, 32'(valid_col),  32'd0);
        check_val({tag, "_data"},  32'(data_col),   32'd0);
        check_val({tag, "_lane"},  32'(lane_col),   32'd0);
        check_val({tag, "_empty"}, 32'(fifo_empty), 32'hF);
        check_val({tag, "_full"},  32'(fifo_full),  32'h0);
        check_val({tag, "_ovf"},   32'(overflow),   32'h0);
        check_val({tag, "_idle"},  32'(idle),       32'd1);
`ifdef COL_OVF_CNT_EN
        check_val({tag, "_ovfcnt"}, 32'(ovf_count), 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        default_values = 1'b0;
        ready_col      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din[i] = 8'h00;
            vin[i] = 1'b0;
        end

        // Reset held two cycles, then released with no traffic.
        tick();
        tick();
        check_reset_state("rst");
        default_values = 1'b1;
        tick();
        check_reset_state("rst_rel");

        // Single byte on lane 0: visible one edge after the write edge.
        ready_col = 1'b1;
        vin[0] = 1'b1; din[0] = 8'hA5;
        tick();
        quiet();
        check_val("single_wait_valid", 32'(valid_col), 32'd0);
        check_val("single_empty0", 32'(fifo_empty), 32'hE);
        tick();
        check_out("single", 8'hA5, 2'd0);
        check_val("single_busy_idle", 32'(idle), 32'd0);
        tick();
        check_val("single_drain_valid", 32'(valid_col), 32'd0);
        check_val("single_drain_idle", 32'(idle), 32'd1);

        // Round-robin continues after lane 0: lane 1 wins before lane 0.
        vin[0] = 1'b1; din[0] = 8'h30;
        vin[1] = 1'b1; din[1] = 8'h31;
        tick();
        quiet();
        tick();
        check_out("rr_first", 8'h31, 2'd1);
        tick();
        check_out("rr_second", 8'h30, 2'd0);
        tick();
        check_val("rr_done_valid", 32'(valid_col), 32'd0);

        // Fresh reset so lane 0 has priority again.
        default_values = 1'b0;
        tick();
        default_values = 1'b1;

        // Two all-lane bursts: both drain in lane order 0,1,2,3.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                vin[i] = 1'b1;
                din[i] = 8'(8'h10 + 8'(b * 16) + 8'(i));
            end
            tick();
            quiet();
            for (int i = 0; i < 4; i++) begin
                tick();
                check_out($sformatf("burst%0d_l%0d", b, i), 8'(8'h10 + 8'(b * 16) + 8'(i)), 2'(i));
            end
            tick();
            check_val($sformatf("burst%0d_end", b), 32'(valid_col), 32'd0);
        end

        // Backpressure: lane 2 gets 3 bytes while ready_col is low.
        ready_col = 1'b0;
        vin[2] = 1'b1; din[2] = 8'hB1;
        tick();
        din[2] = 8'hB2;
        tick();
        din[2] = 8'hB3;
        tick();
        quiet();
        for (int c = 0; c < 5; c++) begin
            check_out($sformatf("hold_c%0d", c), 8'hB1, 2'd2);
            tick();
        end
        check_val("hold_empty", 32'(fifo_empty), 32'hB);
        ready_col = 1'b1;
        tick();
        check_out("hold_rel1", 8'hB2, 2'd2);
        tick();
        check_out("hold_rel2", 8'hB3, 2'd2);
        tick();
        check_val("hold_rel_end", 32'(valid_col), 32'd0);

        // Overflow: lane 1 six bytes with output blocked; sixth is dropped.
        ready_col = 1'b0;
        vin[1] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            din[1] = 8'(c);
            tick();
            if (c == 5) begin
                check_val("ovf_full_at4", 32'(fifo_full), 32'h2);
                check_val("ovf_none_yet", 32'(overflow), 32'h0);
            end
        end
        vin[1] = 1'b0;
        check_out("ovf_head", 8'h01, 2'd1);
        check_val("ovf_flag", 32'(overflow), 32'h2);
        check_val("ovf_full", 32'(fifo_full), 32'h2);
`ifdef COL_OVF_CNT_EN
        check_val("ovf_count1", 32'(ovf_count), 32'd1);
`endif
        // Full lane pushed and popped on the same edge: write accepted.
        ready_col = 1'b1;
        vin[1] = 1'b1; din[1] = 8'h07;
        tick();
        vin[1] = 1'b0;
        check_out("fullpop", 8'h02, 2'd1);
        check_val("fullpop_full", 32'(fifo_full), 32'h2);
        check_val("fullpop_ovf", 32'(overflow), 32'h2);
`ifdef COL_OVF_CNT_EN
        check_val("fullpop_ovfcnt", 32'(ovf_count), 32'd1);
`endif
        tick();
        check_out("drain3", 8'h03, 2'd1);
        tick();
        check_out("drain4", 8'h04, 2'd1);
        tick();
        check_out("drain5", 8'h05, 2'd1);
        tick();
        check_out("drain7", 8'h07, 2'd1);
        tick();
        check_val("drain_end_valid", 32'(valid_col), 32'd0);
        check_val("drain_end_ovf", 32'(overflow), 32'h2);

        // Reset mid-operation with lanes partly filled and output valid.
        ready_col = 1'b0;
        vin[0] = 1'b1; din[0] = 8'h40;
        vin[3] = 1'b1; din[3] = 8'h43;
        tick();
        din[0] = 8'h41;
        din[3] = 8'h44;
        tick();
        quiet();
        check_out("mid_pre", 8'h43, 2'd3);
        check_val("mid_pre_empty", 32'(fifo_empty), 32'h6);
        default_values = 1'b0;
        tick();
        check_reset_state("mid_rst");
        default_values = 1'b1;
        ready_col = 1'b1;
        tick();
        check_val("mid_after_valid", 32'(valid_col), 32'd0);
        check_val("mid_after_idle", 32'(idle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
